// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bundle between decode and the immediate generator stage.
// slave is the generator side, master is the producer/consumer side.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_type;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid,
        input  in_instr,
        input  in_tag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_imm,
        output out_type,
        output out_illegal,
        output out_tag
    );

    modport master (
        output in_valid,
        output in_instr,
        output in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_imm,
        input  out_type,
        input  out_illegal,
        input  out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with illegal-opcode counter.
// Define IMMGEN_CSR_EN to emit zero-extended CSR zimm (type Z).
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_gen_pipe_if.slave    bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [2:0] {
        T_NONE = 3'd0,
        T_I    = 3'd1,
        T_S    = 3'd2,
        T_B    = 3'd3,
        T_U    = 3'd4,
        T_J    = 3'd5,
        T_Z    = 3'd6,
        T_RSV  = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam bit IS64 = (XLEN == 64);

    function automatic logic [XLEN-1:0] sext(
        input logic [31:0] v
    );
        return XLEN'($signed(v));
    endfunction

    logic [31:0] ins;
    logic [6:0]  opc;
    logic        s;

    assign ins = bus.in_instr;
    assign opc = ins[6:0];
    assign s   = ins[31];

    logic sys_z;
`ifdef IMMGEN_CSR_EN
    assign sys_z = (opc == OPC_SYSTEM) && ins[14];
`else
    assign sys_z = 1'b0;
`endif

    logic is_i;
    logic is_s;
    logic is_b;
    logic is_u;
    logic is_j;

    assign is_i = (opc == OPC_OPIMM)
                | (opc == OPC_LOAD)
                | (opc == OPC_JALR)
                | (IS64 && (opc == OPC_OPIMM32))
                | ((opc == OPC_SYSTEM) && !sys_z);
    assign is_s = (opc == OPC_STORE);
    assign is_b = (opc == OPC_BRANCH);
    assign is_u = (opc == OPC_LUI) | (opc == OPC_AUIPC);
    assign is_j = (opc == OPC_JAL);

    // Formats are assembled at 32 bits, then sign-extended to XLEN.
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{s}}, ins[31:20]};
    assign imm_s = {{20{s}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{s}}, s, ins[7], ins[30:25],
                    ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{s}}, s, ins[19:12], ins[20],
                    ins[30:21], 1'b0};

    logic [XLEN-1:0] d_imm;
    imm_type_e       d_type;
    logic            d_ill;

    always_comb begin
        d_imm  = '0;
        d_type = T_NONE;
        d_ill  = 1'b0;
        unique case (1'b1)
            is_i: begin
                d_imm  = sext(imm_i);
                d_type = T_I;
            end
            is_s: begin
                d_imm  = sext(imm_s);
                d_type = T_S;
            end
            is_b: begin
                d_imm  = sext(imm_b);
                d_type = T_B;
            end
            is_u: begin
                d_imm  = sext(imm_u);
                d_type = T_U;
            end
            is_j: begin
                d_imm  = sext(imm_j);
                d_type = T_J;
            end
`ifdef IMMGEN_CSR_EN
            sys_z: begin
                d_imm  = XLEN'(ins[19:15]);
                d_type = T_Z;
            end
`endif
            default: begin
                d_ill = 1'b1;
            end
        endcase
    end

    logic accept;
    logic cnt_sat;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign cnt_sat      = &illegal_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Data registers only move on acceptance; a drain leaves them as-is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_imm     <= '0;
            bus.out_type    <= T_NONE;
            bus.out_illegal <= 1'b0;
            bus.out_tag     <= '0;
        end else if (accept) begin
            bus.out_imm     <= d_imm;
            bus.out_type    <= d_type;
            bus.out_illegal <= d_ill;
            bus.out_tag     <= bus.in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (cnt_clr) begin
            illegal_cnt <= '0;
        end else if (accept && d_ill && !cnt_sat) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: RV32/CNT16 and RV64/CNT2 instances on one stimulus.
// Reference decodes immediates arithmetically from the ISA field rules.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        cnt_clr;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(16)) dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (b32.slave),
        .cnt_clr     (cnt_clr),
        .illegal_cnt (cnt0)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(2)) dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (b64.slave),
        .cnt_clr     (cnt_clr),
        .illegal_cnt (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nvec = 0;
    int nerr = 0;

    logic        iv;
    logic        ordy;
    logic [31:0] ins;
    logic [31:0] tag;

    bit          mv;
    logic [63:0] mimm [2];
    logic [2:0]  mty  [2];
    logic        mil  [2];
    logic [31:0] mtag;
    int unsigned mcnt [2];
    int unsigned cmax [2] = '{65535, 3};

    task automatic chk(input string nm, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    function automatic void ref_dec(input logic [31:0] w, input bit x64,
                                    output logic [63:0] imm,
                                    output logic [2:0] ty,
                                    output logic il);
        longint v;
        logic [6:0] op;
        op = w[6:0];
        v  = 0;
        ty = 3'd0;
        il = 1'b0;
        case (op)
            7'h13, 7'h03, 7'h67: begin
                v = longint'($signed(w[31:20])); ty = 3'd1;
            end
            7'h1b: begin
                if (x64) begin
                    v = longint'($signed(w[31:20])); ty = 3'd1;
                end else il = 1'b1;
            end
            7'h73: begin
`ifdef IMMGEN_CSR_EN
                if (w[14]) begin
                    v = longint'(w[19:15]); ty = 3'd6;
                end else begin
                    v = longint'($signed(w[31:20])); ty = 3'd1;
                end
`else
                v = longint'($signed(w[31:20])); ty = 3'd1;
`endif
            end
            7'h23: begin
                v = longint'($signed(w[31:25])) * 32
                  + longint'(w[11:7]);
                ty = 3'd2;
            end
            7'h63: begin
                v = (w[31] ? -longint'(4096) : 0)
                  + longint'(w[7]) * 2048
                  + longint'(w[30:25]) * 32
                  + longint'(w[11:8]) * 2;
                ty = 3'd3;
            end
            7'h37, 7'h17: begin
                v = longint'($signed(w[31:12])) * 4096; ty = 3'd4;
            end
            7'h6f: begin
                v = (w[31] ? -longint'(1048576) : 0)
                  + longint'(w[19:12]) * 4096
                  + longint'(w[20]) * 2048
                  + longint'(w[30:21]) * 2;
                ty = 3'd5;
            end
            default: il = 1'b1;
        endcase
        imm = v;
        if (!x64) imm[63:32] = 32'h0;
    endfunction

    task automatic drive(input logic v, input logic [31:0] w,
                         input logic [31:0] t, input logic r,
                         input logic c);
        iv = v; ins = w; tag = t; ordy = r; cnt_clr = c;
        b32.in_valid = v; b32.in_instr = w;
        b32.in_tag = t; b32.out_ready = r;
        b64.in_valid = v; b64.in_instr = w;
        b64.in_tag = t; b64.out_ready = r;
    endtask

    task automatic model_reset();
        mv = 1'b0; mtag = '0;
        for (int k = 0; k < 2; k++) begin
            mimm[k] = '0; mty[k] = '0; mil[k] = 1'b0; mcnt[k] = 0;
        end
    endtask

    task automatic check_all();
        chk("valid32", 64'(b32.out_valid), 64'(mv));
        chk("valid64", 64'(b64.out_valid), 64'(mv));
        chk("ready32", 64'(b32.in_ready), 64'(!mv || ordy));
        chk("ready64", 64'(b64.in_ready), 64'(!mv || ordy));
        chk("imm32", 64'(b32.out_imm), mimm[0]);
        chk("imm64", b64.out_imm, mimm[1]);
        chk("type32", 64'(b32.out_type), 64'(mty[0]));
        chk("type64", 64'(b64.out_type), 64'(mty[1]));
        chk("ill32", 64'(b32.out_illegal), 64'(mil[0]));
        chk("ill64", 64'(b64.out_illegal), 64'(mil[1]));
        chk("tag32", 64'(b32.out_tag), 64'(mtag));
        chk("tag64", 64'(b64.out_tag), 64'(mtag));
        chk("cnt16", 64'(cnt0), 64'(mcnt[0]));
        chk("cnt2", 64'(cnt1), 64'(mcnt[1]));
    endtask

    task automatic tick();
        bit acc;
        logic [63:0] ri [2];
        logic [2:0]  rt [2];
        logic        rl [2];
        acc = iv && (!mv || ordy);
        for (int k = 0; k < 2; k++) ref_dec(ins, k == 1, ri[k], rt[k], rl[k]);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (acc) begin
                mimm[k] = ri[k]; mty[k] = rt[k]; mil[k] = rl[k];
            end
            if (cnt_clr) mcnt[k] = 0;
            else if (acc && rl[k] && mcnt[k] < cmax[k]) mcnt[k]++;
        end
        if (acc) begin
            mtag = tag; mv = 1'b1;
        end else if (ordy) mv = 1'b0;
        check_all();
    endtask

    logic [6:0] opl [12] = '{7'h13, 7'h03, 7'h67, 7'h1b, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6f, 7'h73, 7'h00, 7'h7f};

    initial begin
        logic [31:0] w;
        rst_n = 1'b0;
        model_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        check_all();
        @(posedge clk); #1;
        check_all();
        rst_n = 1'b1;

        drive(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
        tick();
        chk("addi_imm", 64'(b32.out_imm), 64'hFFFFFFFF);
        chk("addi_type", 64'(b32.out_type), 64'd1);
        drive(1'b1, 32'hFE112E23, 32'h104, 1'b1, 1'b0);
        tick();
        chk("sw_imm", 64'(b32.out_imm), 64'hFFFFFFFC);
        chk("sw_type", 64'(b32.out_type), 64'd2);
        chk("sw_ready", 64'(b32.in_ready), 64'd1);

        drive(1'b1, 32'hFE000CE3, 32'h108, 1'b1, 1'b0);
        tick();
        chk("beq_imm", 64'(b32.out_imm), 64'hFFFFFFF8);
        chk("beq_imm64", b64.out_imm, 64'hFFFFFFFFFFFFFFF8);
        chk("beq_type", 64'(b32.out_type), 64'd3);
        drive(1'b1, 32'h123452B7, 32'h10C, 1'b1, 1'b0);
        tick();
        chk("lui_imm", 64'(b32.out_imm), 64'h12345000);
        chk("lui_type", 64'(b32.out_type), 64'd4);
        drive(1'b1, 32'h0010006F, 32'h110, 1'b1, 1'b0);
        tick();
        chk("jal_imm", 64'(b32.out_imm), 64'h00000800);
        chk("jal_type", 64'(b32.out_type), 64'd5);

        drive(1'b1, 32'h00500093, 32'h114, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_ready", 64'(b32.in_ready), 64'd0);
            chk("bp_imm", 64'(b32.out_imm), 64'h800);
            chk("bp_tag", 64'(b32.out_tag), 64'h110);
        end
        drive(1'b1, 32'h00500093, 32'h114, 1'b1, 1'b0);
        tick();
        chk("rel_imm", 64'(b32.out_imm), 64'h5);
        chk("rel_tag", 64'(b32.out_tag), 64'h114);
        drive(1'b0, 32'h00500093, 32'h114, 1'b1, 1'b0);
        tick();
        chk("drain_valid", 64'(b32.out_valid), 64'd0);

        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h0, 32'h200 + 32'(i), 1'b1, 1'b0);
            tick();
            chk("ill_flag", 64'(b32.out_illegal), 64'd1);
            chk("ill_imm", 64'(b32.out_imm), 64'd0);
            chk("ill_type", 64'(b32.out_type), 64'd0);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("cnt_two", 64'(cnt0), 64'd2);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h0, 32'h300, 1'b1, 1'b0);
            tick();
        end
        chk("cnt_sat", 64'(cnt1), 64'd3);
        chk("cnt_seven", 64'(cnt0), 64'd7);
        drive(1'b1, 32'h0, 32'h301, 1'b1, 1'b1);
        tick();
        chk("clr_wins32", 64'(cnt0), 64'd0);
        chk("clr_wins64", 64'(cnt1), 64'd0);

        drive(1'b1, 32'h3400D073, 32'h400, 1'b1, 1'b0);
        tick();
`ifdef IMMGEN_CSR_EN
        chk("csr_imm", 64'(b32.out_imm), 64'h1);
        chk("csr_type", 64'(b32.out_type), 64'd6);
`else
        chk("csr_imm", 64'(b32.out_imm), 64'h340);
        chk("csr_type", 64'(b32.out_type), 64'd1);
`endif

        for (int i = 0; i < 400; i++) begin
            w = $urandom();
            w[6:0] = opl[$urandom_range(11)];
            if ($urandom_range(7) == 0) w[6:0] = 7'($urandom());
            drive(1'($urandom_range(3) != 0), w, $urandom(),
                  1'($urandom_range(2) != 0),
                  1'($urandom_range(15) == 0));
            tick();
        end

        drive(1'b1, 32'hFFF00093, 32'h500, 1'b0, 1'b0);
        tick();
        tick();
        chk("pre_rst_valid", 64'(b32.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
